// File: rtl/mem_mult_engine.sv
// Memory-to-memory multiply engine: reads NUM_PAIRS big-endian operand pairs,
// multiplies each with a radix-2 shift-add loop and writes the 2W-bit product back.
module mem_mult_engine #(
    parameter int unsigned OP_BYTES  = 2,
    parameter int unsigned NUM_PAIRS = 16,
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 64,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_signed,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);
    localparam int unsigned W     = 8 * OP_BYTES;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned RANGE = 2 * NUM_PAIRS * OP_BYTES;
    localparam int unsigned CW    = 6;
    localparam int unsigned KW    = 6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Reject illegal parameterisations at elaboration
    if (OP_BYTES < 1 || OP_BYTES > 4) begin : g_bad_op_bytes
        $error("mem_mult_engine: OP_BYTES must be 1..4");
    end
    if (NUM_PAIRS < 1 || NUM_PAIRS > 32) begin : g_bad_num_pairs
        $error("mem_mult_engine: NUM_PAIRS must be 1..32");
    end
    if (64'(SRC_BASE) + 64'(RANGE) > (64'(1) << AW) ||
        64'(DST_BASE) + 64'(RANGE) > (64'(1) << AW)) begin : g_bad_range
        $error("mem_mult_engine: operand or product range exceeds address space");
    end
    if (SRC_BASE < DST_BASE + RANGE && DST_BASE < SRC_BASE + RANGE) begin : g_overlap
        $error("mem_mult_engine: source and destination ranges overlap");
    end

    logic [2:0]    state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sgn, sgn_nxt;
    logic [W-1:0]  a, a_nxt, b, b_nxt;
    logic [PW-1:0] acc, acc_nxt;
    logic [AW-1:0] addr_nxt;
    logic [7:0]    wdata_nxt;
    logic          wr_en_nxt, done_nxt, busy_nxt;

    logic [31:0]   k32, cnt32, base_a, base_b, base_d;
    logic [W-1:0]  mag_a, mag_b;
    logic          b_bit, neg;
    logic [PW-1:0] term, prod_sum;

    assign k32    = 32'(k);
    assign cnt32  = 32'(cnt);
    assign base_a = SRC_BASE + 32'(2 * OP_BYTES) * k32;
    assign base_b = base_a + 32'(OP_BYTES);
    assign base_d = DST_BASE + 32'(2 * OP_BYTES) * k32;

    // Shift-add on magnitudes; sign is reapplied after the last step
    assign mag_a    = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    assign mag_b    = (sgn && b[W-1]) ? (~b + W'(1)) : b;
    assign b_bit    = |(mag_b & (W'(1) << cnt));
    assign neg      = sgn & (a[W-1] ^ b[W-1]);
    assign term     = PW'(mag_a) << cnt;
    assign prod_sum = acc + (b_bit ? term : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= '0;
            cnt         <= '0;
            sgn         <= 1'b0;
            a           <= '0;
            b           <= '0;
            acc         <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_en   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            cnt         <= cnt_nxt;
            sgn         <= sgn_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            acc         <= acc_nxt;
            mem_addr    <= addr_nxt;
            mem_wr_data <= wdata_nxt;
            mem_wr_en   <= wr_en_nxt;
            done        <= done_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        cnt_nxt   = cnt;
        sgn_nxt   = sgn;
        a_nxt     = a;
        b_nxt     = b;
        acc_nxt   = acc;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wr_data;
        wr_en_nxt = 1'b0;

        if (start) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_LOAD_A;
                    k_nxt     = '0;
                    cnt_nxt   = '0;
                    sgn_nxt   = is_signed;
                    addr_nxt  = AW'(SRC_BASE);
                end
                // Read data lags the address by one cycle, so byte i lands in cycle i+1
                S_LOAD_A: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt != '0) a_nxt = (a << 8) | W'(mem_rd_data);
                    if (cnt < CW'(OP_BYTES - 1)) addr_nxt = AW'(base_a + cnt32 + 32'd1);
                    if (cnt == CW'(OP_BYTES)) begin
                        state_nxt = S_LOAD_B;
                        cnt_nxt   = '0;
                        addr_nxt  = AW'(base_b);
                    end
                end
                S_LOAD_B: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt != '0) b_nxt = (b << 8) | W'(mem_rd_data);
                    if (cnt < CW'(OP_BYTES - 1)) addr_nxt = AW'(base_b + cnt32 + 32'd1);
                    if (cnt == CW'(OP_BYTES)) begin
                        state_nxt = S_MUL;
                        cnt_nxt   = '0;
                        acc_nxt   = '0;
                    end
                end
                S_MUL: begin
                    cnt_nxt = cnt + CW'(1);
                    acc_nxt = prod_sum;
                    if (cnt == CW'(W - 1)) begin
                        acc_nxt   = neg ? (~prod_sum + PW'(1)) : prod_sum;
                        state_nxt = S_STORE;
                        cnt_nxt   = '0;
                        addr_nxt  = AW'(base_d);
                        wdata_nxt = acc_nxt[PW-1 -: 8];
                        wr_en_nxt = 1'b1;
                    end
                end
                S_STORE: begin
                    if (cnt == CW'(2 * OP_BYTES - 1)) begin
                        cnt_nxt = '0;
                        if (k == KW'(NUM_PAIRS - 1)) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_LOAD_A;
                            k_nxt     = k + KW'(1);
                            addr_nxt  = AW'(base_a + 32'(2 * OP_BYTES));
                        end
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        acc_nxt   = acc << 8;
                        addr_nxt  = mem_addr + AW'(1);
                        wdata_nxt = acc[PW-9 -: 8];
                        wr_en_nxt = 1'b1;
                    end
                end
                S_DONE: state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end

        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end
endmodule

// File: tb/tb_mem_mult_engine.sv
// Bench for mem_mult_engine: a default instance and a one-byte, one-pair instance,
// each against a cycle-level arithmetic model of the run timeline.
module tb_mem_mult_engine;
    localparam int OB  = 2;
    localparam int N   = 16;
    localparam int LAT = 12 * OB + 2;

    logic clk = 1'b0;
    logic rst, start0, start1, sg0, sg1, ld;
    logic done0, busy0, we0, done1, busy1, we1;
    logic [7:0] addr0, rd0, wd0, addr1, rd1, wd1;

    logic [7:0] mem0 [0:255];
    logic [7:0] mem1 [0:255];
    logic [7:0] img  [0:63];
    logic [7:0] expb0 [0:63];
    logic [7:0] expb1 [0:63];
    logic [7:0] lit_b [0:15];

    bit trk0, trk1, st0_s, st1_s, memchk;
    int e0, e1, lit_n, lit_edge0, lit_edge1, msel, mpairs;
    int nvec, nmis;

    always #5 clk = ~clk;

    mem_mult_engine dut (
        .clk(clk), .reset(rst), .start(start0), .is_signed(sg0),
        .done(done0), .busy(busy0), .mem_addr(addr0), .mem_rd_data(rd0),
        .mem_wr_en(we0), .mem_wr_data(wd0)
    );

    mem_mult_engine #(.OP_BYTES(1), .NUM_PAIRS(1)) dut1 (
        .clk(clk), .reset(rst), .start(start1), .is_signed(sg1),
        .done(done1), .busy(busy1), .mem_addr(addr1), .mem_rd_data(rd1),
        .mem_wr_en(we1), .mem_wr_data(wd1)
    );

    // Byte memories with one-cycle read latency; ld reloads sources and poisons destinations
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= (i < 64) ? img[i % 64] : 8'hA5;
                mem1[i] <= (i < 64) ? img[i % 64] : 8'hA5;
            end
        end else begin
            if (we0) mem0[addr0] <= wd0;
            if (we1) mem1[addr1] <= wd1;
        end
        rd0   <= mem0[addr0];
        rd1   <= mem1[addr1];
        e0    <= trk0 ? e0 + 1 : 0;
        e1    <= trk1 ? e1 + 1 : 0;
        st0_s <= start0;
        st1_s <= start1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected outputs at edge count e of a run: pair p, offset o; stores fill the last 2*ob cycles
    task automatic cyc(input string nm, input int e, input int ob, input int n,
                       input logic bsy, input logic dn, input logic we,
                       input logic [7:0] ad, input logic [7:0] wd,
                       input logic [7:0] eb [0:63]);
        int lat, p, o, j;
        bit ew;
        lat = 12 * ob + 2;
        p   = (e >= 1) ? (e - 1) / lat : 0;
        o   = (e >= 1) ? (e - 1) % lat : 0;
        j   = o - (lat - 2 * ob);
        ew  = (e >= 1) && (e <= n * lat) && (j >= 0);
        chk({nm, ".busy"}, bsy, (e >= 1 && e <= n * lat) ? 1 : 0);
        chk({nm, ".done"}, dn, (e > n * lat) ? 1 : 0);
        chk({nm, ".wr_en"}, we, ew ? 1 : 0);
        if (ew) begin
            chk({nm, ".addr"}, ad, 64 + p * 2 * ob + j);
            chk({nm, ".wr_data"}, wd, eb[p * 2 * ob + j]);
        end
    endtask

    task automatic memcheck(input int d);
        int ob, nb;
        logic [7:0] act, exp;
        ob = d ? 1 : OB;
        nb = d ? 2 : 2 * OB * N;
        for (int i = 0; i < 64; i++) chk("src_intact", d ? mem1[i] : mem0[i], img[i]);
        for (int j = 0; j < nb; j++) begin
            act = d ? mem1[64 + j] : mem0[64 + j];
            exp = (j / (2 * ob) < mpairs) ? (d ? expb1[j] : expb0[j]) : 8'hA5;
            chk("dst_byte", act, exp);
        end
        for (int j = 0; j < lit_n; j++) begin
            chk("dst_literal", d ? mem1[64 + j] : mem0[64 + j], lit_b[j]);
            chk("model_literal", d ? expb1[j] : expb0[j], lit_b[j]);
        end
    endtask

    // Single compare process
    always @(negedge clk) begin
        if (rst) begin
            chk("rst.done", done0, 0); chk("rst.busy", busy0, 0); chk("rst.wr_en", we0, 0);
            chk("rst.addr", addr0, 0); chk("rst.wr_data", wd0, 0);
            chk("rst1.done", done1, 0); chk("rst1.busy", busy1, 0); chk("rst1.wr_en", we1, 0);
            chk("rst1.addr", addr1, 0); chk("rst1.wr_data", wd1, 0);
        end else begin
            if (trk0) cyc("run0", e0, OB, N, busy0, done0, we0, addr0, wd0, expb0);
            else if (st0_s) begin
                chk("idle0.busy", busy0, 0); chk("idle0.done", done0, 0); chk("idle0.wr_en", we0, 0);
            end
            if (trk1) cyc("run1", e1, 1, 1, busy1, done1, we1, addr1, wd1, expb1);
            else if (st1_s) begin
                chk("idle1.busy", busy1, 0); chk("idle1.done", done1, 0); chk("idle1.wr_en", we1, 0);
            end
            if (trk0 && lit_edge0 != 0 && e0 == lit_edge0 - 1) chk("done0_before_edge", done0, 0);
            if (trk0 && lit_edge0 != 0 && e0 == lit_edge0) chk("done0_at_edge", done0, 1);
            if (trk1 && lit_edge1 != 0 && e1 == lit_edge1 - 1) chk("done1_before_edge", done1, 0);
            if (trk1 && lit_edge1 != 0 && e1 == lit_edge1) chk("done1_at_edge", done1, 1);
            if (memchk) memcheck(msel);
        end
    end

    function automatic longint pmodel(input int ob, input bit s, input longint a, input longint b);
        longint m, x, y;
        m = longint'(1) << (8 * ob);
        x = (s && a >= m / 2) ? a - m : a;
        y = (s && b >= m / 2) ? b - m : b;
        return x * y;
    endfunction

    task automatic build(input int ob, input int n, input bit s, output logic [7:0] eb [0:63]);
        longint a, b, p;
        for (int i = 0; i < 64; i++) eb[i] = 8'h00;
        for (int k = 0; k < n; k++) begin
            a = 0; b = 0;
            for (int i = 0; i < ob; i++) begin
                a = (a << 8) | longint'(img[2 * k * ob + i]);
                b = (b << 8) | longint'(img[(2 * k + 1) * ob + i]);
            end
            p = pmodel(ob, s, a, b);
            for (int j = 0; j < 2 * ob; j++) eb[k * 2 * ob + j] = 8'((p >>> (8 * (2 * ob - 1 - j))) & 255);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_img();
        for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic load0(input bit s);
        sg0 = s;
        build(OB, N, s, expb0);
        ld = 1'b1; tick(); ld = 1'b0;
    endtask

    task automatic check_mem(input int d, input int pairs);
        msel = d; mpairs = pairs; memchk = 1'b1;
        tick();
        memchk = 1'b0;
    endtask

    task automatic full_run0();
        start0 = 1'b0; trk0 = 1'b1;
        repeat (N * LAT + 3) tick();
        check_mem(0, N);
        start0 = 1'b1; trk0 = 1'b0; lit_n = 0; lit_edge0 = 0;
        tick(); tick();
    endtask

    task automatic run_until0(input int stop_e);
        start0 = 1'b0; trk0 = 1'b1;
        for (int c = 0; c < N * LAT + 10 && e0 != stop_e; c++) tick();
        if (e0 != stop_e) chk("reach_edge", e0, stop_e);
    endtask

    task automatic set_lit(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, input int n);
        lit_b[0] = b0; lit_b[1] = b1; lit_b[2] = b2; lit_b[3] = b3;
        lit_b[4] = b4; lit_b[5] = b5; lit_b[6] = b6; lit_b[7] = b7;
        lit_n = n;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1; sg0 = 1'b0; sg1 = 1'b0; ld = 1'b0;
        trk0 = 1'b0; trk1 = 1'b0; memchk = 1'b0; msel = 0; mpairs = 0;
        lit_n = 0; lit_edge0 = 0; lit_edge1 = 0; nvec = 0; nmis = 0;
        for (int i = 0; i < 16; i++) lit_b[i] = 8'h00;
        rand_img();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Signed directed pairs: 3*-2, min*min, max*min
        rand_img();
        img[0] = 8'h00; img[1] = 8'h03; img[2] = 8'hFF; img[3] = 8'hFE;
        img[4] = 8'h80; img[5] = 8'h00; img[6] = 8'h80; img[7] = 8'h00;
        img[8] = 8'h7F; img[9] = 8'hFF; img[10] = 8'h80; img[11] = 8'h00;
        load0(1'b1);
        set_lit(8'hFF, 8'hFF, 8'hFF, 8'hFA, 8'h40, 8'h00, 8'h00, 8'h00, 8);
        lit_edge0 = 417;
        full_run0();
        set_lit(8'hC0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4);
        for (int j = 0; j < 4; j++) lit_b[j] = lit_b[j];
        msel = 0;
        // pair 2 literal lives at destination offset 8
        chk_pair2: begin
            lit_n = 0;
        end

        // Unsigned directed pairs
        rand_img();
        img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hFF; img[3] = 8'hFF;
        img[4] = 8'h00; img[5] = 8'h00; img[6] = 8'h12; img[7] = 8'h34;
        load0(1'b0);
        set_lit(8'hFF, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8);
        lit_edge0 = 417;
        full_run0();

        // Signed max*min at pair 0 pins the third directed product
        rand_img();
        img[0] = 8'h7F; img[1] = 8'hFF; img[2] = 8'h80; img[3] = 8'h00;
        load0(1'b1);
        set_lit(8'hC0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4);
        full_run0();

        // Abort by start during pair 1 multiply: pair 0 kept, nothing else written
        rand_img();
        load0(1'b1);
        run_until0(40);
        start0 = 1'b1; trk0 = 1'b0;
        tick(); tick();
        check_mem(0, 1);

        // Reset during pair 3 multiply, then a clean rerun from pair 0
        rand_img();
        load0(1'b0);
        run_until0(89);
        rst = 1'b1; start0 = 1'b1; trk0 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_mem(0, 3);
        load0(1'b0);
        full_run0();

        // Random runs in both modes
        for (int r = 0; r < 10; r++) begin
            rand_img();
            load0(r % 2 == 0);
            full_run0();
        end

        // One-byte, one-pair instance: 0x80 * 0x7F signed, then identical rerun
        rand_img();
        img[0] = 8'h80; img[1] = 8'h7F;
        sg1 = 1'b1;
        build(1, 1, 1'b1, expb1);
        ld = 1'b1; tick(); ld = 1'b0;
        set_lit(8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        lit_edge1 = 15;
        start1 = 1'b0; trk1 = 1'b1;
        repeat (18) tick();
        check_mem(1, 1);
        start1 = 1'b1; trk1 = 1'b0; ld = 1'b1;
        tick();
        ld = 1'b0; start1 = 1'b0; trk1 = 1'b1;
        repeat (18) tick();
        check_mem(1, 1);
        start1 = 1'b1; trk1 = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
